// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the stage2 branch resolve unit: branch funct3 encodings
// and the 2-bit saturating predictor counter states.
package branch_resolve_unit_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  localparam logic [1:0] CNT_RESET = WNT;

endpackage

// File: rtl/branch_resolve_unit_sat_counter2.sv
// Next-state logic for one 2-bit saturating predictor counter.
module sat_counter2
  import branch_resolve_unit_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Stage2 conditional-branch resolution, mispredict redirect, BHT of 2-bit
// counters (read by stage1, written by stage2) and branch statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 32,
  parameter logic [1:0]  CNT_RESET   = branch_resolve_unit_pkg::CNT_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s1_pc,
  output logic        s1_pred_taken,
  input  logic        s2_valid,
  input  logic        s2_is_branch,
  input  logic [2:0]  s2_funct3,
  input  logic [31:0] s2_pc,
  input  logic [31:0] s2_target,
  input  logic        s2_pred_taken,
  input  logic        stall,
  output logic        cmp_signed,
  input  logic        cmp_eq,
  input  logic        cmp_lt,
  output logic        br_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [31:0]      stat_branches_q, stat_mispredicts_q;
  logic [IDX_W-1:0] s1_idx, s2_idx;
  logic             outcome, f3_legal, br_ok, upd;
  logic [1:0]       cnt_next;
  logic             unused_pc_bits;

  assign s1_idx = s1_pc[IDX_W+1:2];
  assign s2_idx = s2_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{s1_pc[31:IDX_W+2], s1_pc[1:0]};

  // No write-through: a same-index stage2 update is seen by stage1 next cycle.
  assign s1_pred_taken = bht_q[s1_idx][1];
  assign cmp_signed    = ~s2_funct3[1];

  always_comb begin
    outcome  = 1'b0;
    f3_legal = 1'b1;
    case (s2_funct3)
      BR_EQ:          outcome = cmp_eq;
      BR_NE:          outcome = ~cmp_eq;
      BR_LT, BR_LTU:  outcome = cmp_lt;
      BR_GE, BR_GEU:  outcome = ~cmp_lt;
      default:        f3_legal = 1'b0;
    endcase
  end

  assign br_ok       = s2_valid & s2_is_branch & f3_legal;
  assign br_taken    = br_ok & outcome;
  assign redirect    = br_ok & (outcome != s2_pred_taken);
  assign redirect_pc = !redirect ? '0 : (outcome ? s2_target : s2_pc + 32'd4);
  assign upd         = br_ok & ~stall;

  sat_counter2 u_sat_counter2 (
    .cnt_i   (bht_q[s2_idx]),
    .taken_i (outcome),
    .cnt_o   (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_RESET;
    end else if (upd) begin
      bht_q[s2_idx] <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (upd) begin
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
      if (redirect && stat_mispredicts_q != '1)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: combinational vector table plus
// hand-written sequences for table update, saturation, stall and reset.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, s1_pred_taken, s2_valid, s2_is_branch, s2_pred_taken, stall;
  logic [31:0] s1_pc, s2_pc, s2_target, redirect_pc, stat_branches, stat_mispredicts;
  logic [2:0]  s2_funct3;
  logic        cmp_signed, cmp_eq, cmp_lt, br_taken, redirect;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.BHT_ENTRIES(32)) dut (
    .clk(clk), .reset(reset), .s1_pc(s1_pc), .s1_pred_taken(s1_pred_taken),
    .s2_valid(s2_valid), .s2_is_branch(s2_is_branch), .s2_funct3(s2_funct3),
    .s2_pc(s2_pc), .s2_target(s2_target), .s2_pred_taken(s2_pred_taken),
    .stall(stall), .cmp_signed(cmp_signed), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .br_taken(br_taken), .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        eq, lt, pred, valid, isb;
    logic [31:0] pc, tgt;
    logic        e_sig, e_taken, e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic eq, input logic lt, input logic pred,
                       input logic valid, input logic isb, input logic [31:0] pc,
                       input logic [31:0] tgt);
    s2_funct3 = f3; cmp_eq = eq; cmp_lt = lt; s2_pred_taken = pred;
    s2_valid = valid; s2_is_branch = isb; s2_pc = pc; s2_target = tgt;
  endtask

  task automatic idle();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pred_at(input string name, input logic [31:0] pc, input logic exp);
    s1_pc = pc;
    #1;
    check(name, {31'd0, s1_pred_taken}, {31'd0, exp});
  endtask

  task automatic stats(input string name, input logic [31:0] b, input logic [31:0] m);
    check({name, "_branches"}, stat_branches, b);
    check({name, "_mispredicts"}, stat_mispredicts, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{BR_EQ,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200,  1'b1, 1'b1, 1'b1, 32'h200};
    vecs[1]  = '{BR_EQ,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200,  1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{BR_NE,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h80,   1'b1, 1'b1, 1'b1, 32'h80};
    vecs[3]  = '{BR_NE,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h80,   1'b1, 1'b0, 1'b1, 32'h108};
    vecs[4]  = '{BR_LT,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10,  32'h50,   1'b1, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{BR_GE,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10,  32'h50,   1'b1, 1'b0, 1'b1, 32'h14};
    vecs[6]  = '{BR_LTU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{BR_GEU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20,  32'h300,  1'b0, 1'b1, 1'b1, 32'h300};
    vecs[8]  = '{3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20,  32'h300,  1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20,  32'h300,  1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{BR_EQ,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200,  1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{BR_NE,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200,  1'b1, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{BR_LTU, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20,  32'h1000, 1'b0, 1'b1, 1'b1, 32'h1000};
    vecs[13] = '{BR_GEU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h30,  32'h1000, 1'b0, 1'b0, 1'b1, 32'h34};

    // Reset state
    reset = 1'b1; stall = 1'b0; s1_pc = 32'h0; idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    pred_at("rst_pred_0", 32'h0, 1'b0);
    pred_at("rst_pred_100", 32'h100, 1'b0);
    pred_at("rst_pred_fc", 32'hFFFF_FFFC, 1'b0);
    stats("rst", 32'd0, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);

    // Combinational vectors, held under stall so no state changes
    stall = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].f3, vecs[i].eq, vecs[i].lt, vecs[i].pred, vecs[i].valid, vecs[i].isb,
            vecs[i].pc, vecs[i].tgt);
      #1;
      check($sformatf("v%0d_cmp_signed", i), {31'd0, cmp_signed}, {31'd0, vecs[i].e_sig});
      check($sformatf("v%0d_br_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].e_taken});
      check($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
      check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      tick();
    end
    idle(); stall = 1'b0;
    #1;
    stats("vec_stall", 32'd0, 32'd0);
    pred_at("vec_stall_pred_100", 32'h100, 1'b0);

    // BEQ taken at 0x100, predicted not-taken; same-index read sees old value
    drive(BR_EQ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200);
    pred_at("beq_same_idx_old", 32'h100, 1'b0);
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_redirect_pc", redirect_pc, 32'h200);
    tick(); idle();
    pred_at("beq_pred_after", 32'h100, 1'b1);
    pred_at("alias_pred_80", 32'h80, 1'b1);
    stats("beq", 32'd1, 32'd1);

    // BLTU not-taken at top of memory: fall-through wraps to 0
    drive(BR_LTU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40);
    #1;
    check("bltu_cmp_signed", {31'd0, cmp_signed}, 32'd0);
    check("bltu_redirect", {31'd0, redirect}, 32'd1);
    check("bltu_redirect_pc", redirect_pc, 32'h0);
    tick(); idle();
    stats("bltu", 32'd2, 32'd2);

    // Saturation at 3: four taken BNE at 0x40 then two not-taken
    for (int i = 0; i < 4; i++) begin
      drive(BR_NE, 1'b0, 1'b0, (i != 0), 1'b1, 1'b1, 32'h40, 32'h400);
      tick();
      pred_at($sformatf("sat_up%0d_pred", i), 32'h40, 1'b1);
    end
    drive(BR_NE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h400);
    tick();
    pred_at("sat_nt1_pred", 32'h40, 1'b1);
    drive(BR_NE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h400);
    tick(); idle();
    pred_at("sat_nt2_pred", 32'h40, 1'b0);
    stats("sat", 32'd8, 32'd5);

    // Saturation at 0 (index of 0xFFFF_FFFC is at SNT now)
    drive(BR_LTU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40);
    tick();
    drive(BR_LTU, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40);
    tick();
    pred_at("floor_t1_pred", 32'hFFFF_FFFC, 1'b0);
    tick(); idle();
    pred_at("floor_t2_pred", 32'hFFFF_FFFC, 1'b1);
    stats("floor", 32'd11, 32'd7);

    // Stall freezes table and stats but redirect still asserts
    stall = 1'b1;
    drive(BR_GE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h88, 32'h800);
    #1;
    check("stall_redirect", {31'd0, redirect}, 32'd1);
    check("stall_redirect_pc", redirect_pc, 32'h800);
    tick(); tick();
    pred_at("stall_pred", 32'h88, 1'b0);
    stats("stall", 32'd11, 32'd7);
    stall = 1'b0;
    tick(); idle();
    pred_at("unstall_pred", 32'h88, 1'b1);
    stats("unstall", 32'd12, 32'd8);

    // Illegal funct3 and invalid slot: no outcome, no update
    drive(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h88, 32'h800);
    #1;
    check("illegal_br_taken", {31'd0, br_taken}, 32'd0);
    check("illegal_redirect", {31'd0, redirect}, 32'd0);
    tick();
    drive(BR_EQ, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h88, 32'h800);
    #1;
    check("invalid_redirect", {31'd0, redirect}, 32'd0);
    tick(); idle();
    pred_at("illegal_pred", 32'h88, 1'b1);
    stats("illegal", 32'd12, 32'd8);

    // Reset coincident with a valid branch discards its update
    reset = 1'b1;
    drive(BR_EQ, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h400);
    #1;
    check("rst_branch_redirect", {31'd0, redirect}, 32'd1);
    tick();
    reset = 1'b0; idle();
    pred_at("rst_branch_pred_40", 32'h40, 1'b0);
    pred_at("rst_branch_pred_88", 32'h88, 1'b0);
    stats("rst_branch", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits in stage2 directly downstream of the branch comparator. Drives the comparator's signed-select input and consumes its eq/lt outputs.
- Resolves conditional branches and detects mispredicts against the stage1 prediction. Generates the PC redirect and flush.
- Owns a PC-indexed table of 2-bit saturating counters. Stage1 reads it combinationally for prediction; stage2 updates it. Also keeps branch and mispredict statistics counters.

Parameters:
- BHT_ENTRIES, 32, number of 2-bit counters; must be a power of two, minimum 2.
- IDX_W, $clog2(BHT_ENTRIES), index width; derived, not overridden.
- CNT_RESET, 2'b01, counter value at reset (weakly not-taken).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- s1_pc  in  32  PC of the instruction in stage1
- s1_pred_taken  out  1  prediction for s1_pc: counter[s1_pc[IDX_W+1:2]][1]
- s2_valid  in  1  stage2 holds a real instruction (not bubble/flushed)
- s2_is_branch  in  1  stage2 instruction is a B-type
- s2_funct3  in  3  branch funct3
- s2_pc  in  32  stage2 PC
- s2_target  in  32  computed branch target (pc + imm)
- s2_pred_taken  in  1  prediction carried from stage1
- stall  in  1  pipeline stall; freezes table and stats
- cmp_signed  out  1  to comparator s input: ~s2_funct3[1]
- cmp_eq  in  1  comparator eq
- cmp_lt  in  1  comparator lt
- br_taken  out  1  actual outcome
- redirect  out  1  mispredict; fetch must take redirect_pc, stages 1 and 0 flush
- redirect_pc  out  32  corrected PC
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Legal branch: br_ok = s2_valid & s2_is_branch & funct3 in {000,001,100,101,110,111}. funct3 010/011 give br_ok=0.
- Outcome, combinational:
  - 000: eq
  - 001: !eq
  - 100 and 110: lt
  - 101 and 111: !lt
  - br_taken = br_ok & outcome.
- Mispredict: redirect = br_ok & (outcome != s2_pred_taken), combinational, same cycle.
  - redirect_pc = s2_target when outcome=1; otherwise s2_pc + 4 (mod 2^32 wrap).
  - redirect_pc = 0 when redirect=0.
- redirect is asserted regardless of stall. The upstream pipeline control owns stall/flush priority.
- Table update at clk edge when br_ok & ~stall, at index s2_pc[IDX_W+1:2]:
  - taken: saturating increment, 3 stays 3.
  - not-taken: saturating decrement, 0 stays 0.
- Prediction read is combinational from table flops with no write-through bypass. If the stage1 and stage2 indices match in the same cycle, s1_pred_taken reflects the pre-update value.
- Stats, on br_ok & ~stall:
  - stat_branches += 1.
  - stat_mispredicts += 1 if redirect.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Reset, synchronous, has priority over all updates:
  - every counter = CNT_RESET, so s1_pred_taken = 0.
  - both stats = 0.
  - Combinational outputs follow their inputs; no outputs are held during reset.
- A reset asserted in the same cycle as a valid branch discards that branch's update.
- PC bits [1:0] are ignored for indexing. Aliasing between PCs that share an index is accepted.

Decomposition:
- Shared package holds:
  - funct3 constants BR_EQ=3'b000, BR_NE=3'b001, BR_LT=3'b100, BR_GE=3'b101, BR_LTU=3'b110, BR_GEU=3'b111.
  - CNT_RESET.
  - 2-bit counter state constants SNT=0, WNT=1, WT=2, ST=3.
- One sub-module: sat_counter2. It takes the current value and a taken input and returns the next value. It is combinational and instantiated once, in the update path.
- The table and statistics counters stay in the top module.

Test Plan:
- Reset: assert reset 1 cycle -> s1_pred_taken=0 for any s1_pc; both stats=0; redirect=0.
- BEQ at s2_pc=0x100, eq=1, pred=0 -> br_taken=1, redirect=1, redirect_pc=s2_target. Next cycle counter[0x100>>2 & mask] = WT and s1_pc=0x100 predicts 1. Stats = 1/1.
- BLTU funct3=110, lt=0, pred=1, s2_pc=0xFFFF_FFFC -> cmp_signed=0, redirect_pc=0x0000_0000 (wrap), redirect=1.
- Saturation: 4 consecutive taken BNE (eq=0) at one PC -> counter sequence 1->2->3->3. A following not-taken gives 2, and the prediction stays 1.
- stall=1 with a valid mispredicting BGE -> redirect=1 asserted, but table and stats unchanged. Deassert stall -> update applies once.
- funct3=010 with s2_is_branch=1, and s2_valid=0 with a legal funct3 -> br_taken=0, redirect=0, no table or stat change. Same-index read in an update cycle returns the old counter.
